// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package adder_pkg;

  // Handshake / sequencing states of the bit-serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bsa_state_t;

  // Bit counter width: must hold 0..width so the final increment never wraps.
  function automatic int bsa_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// Single-bit full-adder cell, the datapath element sequenced by bit_serial_adder.
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial add/subtract: one full-adder cell stepped over WIDTH cycles, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module bit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int               CW       = bsa_cnt_width(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  bsa_state_t       state_r;
  bsa_state_t       state_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] sum_sr_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             cout_r;
  logic             ovf_r;
  logic             fa_s_s;
  logic             fa_c_s;
  logic             accept_s;
  logic             last_s;

  // Subtraction needs no separate mode flop: it is folded into the inverted
  // B operand and the initial carry of one, both captured at accept time.
  assign accept_s = in_valid & in_ready_r;
  assign last_s   = (cnt_r == CNT_LAST);

  Full_Adder u_cell (
    .a    (a_sr_r[0]),
    .b    (b_sr_r[0]),
    .cin  (carry_r),
    .s    (fa_s_s),
    .cout (fa_c_s)
  );

  // Next-state decode for the IDLE -> BUSY -> DONE handshake sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus registered handshake flags derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture, per-bit shifting, carry chaining and MSB flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      sum_sr_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_sr_r  <= in_a;
            b_sr_r  <= in_b ^ {WIDTH{in_sub}};
            carry_r <= in_sub;
            cnt_r   <= '0;
          end
        end
        BUSY: begin
          sum_sr_r <= (sum_sr_r >> 1'b1) | (fa_s_s ? MSB_MASK : '0);
          a_sr_r   <= a_sr_r >> 1'b1;
          b_sr_r   <= b_sr_r >> 1'b1;
          carry_r  <= fa_c_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (last_s) begin
            // Signed overflow: carry into the MSB differs from carry out of it.
            ovf_r  <= carry_r ^ fa_c_s;
            cout_r <= fa_c_s;
          end
        end
        DONE: begin
          // Results hold until the consumer takes them.
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = sum_sr_r;
  assign out_cout  = cout_r;
  assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): directed cases, backpressure,
// mid-operation reset and a randomized back-to-back stream against an arithmetic model.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int checks   = 0;
  int failures = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  // Returns {ovf, cout, sum[7:0]}.
  function automatic logic [9:0] ref_model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ua, ub, sa, sb, r, ideal;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      r     = ua - ub;
      cout  = (ua >= ub);
      ideal = sa - sb;
    end else begin
      r     = ua + ub;
      cout  = (r > 255);
      ideal = sa + sb;
    end
    sum = r[7:0];
    ovf = (ideal > 127) || (ideal < -128);
    return {ovf, cout, sum};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid; returns the number of edges waited.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  // One directed transaction with out_ready high; expects the block to be idle.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] esum, input logic ecout,
                        input logic eovf);
    int n;
    check({tag, "_ready"}, in_ready, 1'b1);
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_ready_low"}, in_ready, 1'b0);
    wait_valid(n);
    check({tag, "_latency"}, n, W);
    check({tag, "_sum"}, out_sum, esum);
    check({tag, "_cout"}, out_cout, ecout);
    check({tag, "_ovf"}, out_ovf, eovf);
    tick();
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_idle_ready"}, in_ready, 1'b1);
  endtask

  initial begin : main
    int n;
    int cyc;
    int i;
    int last_acc;
    bit acc;
    bit seen;
    logic [9:0] exp_q[$];
    logic [9:0] e;

    rst = 1'b1; in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_sub = 1'b1; out_ready = 1'b1;
    tick(); tick();
    // Reset with in_valid high: nothing accepted, reset values present.
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", out_sum, 8'h00);
    check("rst_cout", out_cout, 1'b0);
    check("rst_ovf", out_ovf, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_idle", out_valid, 1'b0);

    run_op("add_plain", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_op("add_carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_ovf",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_borrow",8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op("sub_ovf",   8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Backpressure: result held with out_ready low; inputs ignored while busy/done.
    out_ready = 1'b0;
    in_a = 8'h12; in_b = 8'h34; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    n = 0;
    while (!out_valid && n < 50) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom);
      tick();
      n++;
    end
    check("bp_latency", n, W);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_sum", out_sum, 8'h46);
      check("bp_hold_flags", {out_cout, out_ovf}, 2'b00);
      check("bp_no_accept", in_ready, 1'b0);
      in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom);
      tick();
    end
    out_ready = 1'b1;
    in_a = 8'h0F; in_b = 8'h01; in_sub = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    check("bp_next_latency", n, W);
    check("bp_next_sum", out_sum, 8'h0E);
    check("bp_next_flags", {out_cout, out_ovf}, 2'b10);
    tick();

    // Reset during the third BUSY cycle drops the transaction.
    in_a = 8'hAA; in_b = 8'h55; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_sum", out_sum, 8'h00);
    check("mid_rst_flags", {out_cout, out_ovf}, 2'b00);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("mid_rst_no_result", seen, 1'b0);
    run_op("after_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // Back-to-back random stream, in_valid and out_ready held high.
    out_ready = 1'b1;
    i = 0; cyc = 0; last_acc = 0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom); in_valid = 1'b1;
    while ((i < 100 || exp_q.size() > 0) && cyc < 3000) begin
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(ref_model(in_a, in_b, in_sub));
      tick();
      cyc++;
      if (acc) begin
        if (i > 0) check("stream_interval", cyc - last_acc, W + 2);
        last_acc = cyc;
        i++;
        if (i < 100) begin
          in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        check("stream_expected_result", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("stream_sum", out_sum, e[7:0]);
          check("stream_cout", out_cout, e[8]);
          check("stream_ovf", out_ovf, e[9]);
        end
      end
    end
    check("stream_complete", (i == 100) && (exp_q.size() == 0), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
